// File: rtl/tape_pkg.sv
// Shared symbol codes, default geometry and responder FSM states for the tape memory.
package tape_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_SYM_W  = 2;

  localparam logic [1:0] SYM_BLANK = 2'b00;
  localparam logic [1:0] SYM_ZERO  = 2'b01;
  localparam logic [1:0] SYM_ONE   = 2'b10;
  localparam logic [1:0] SYM_HASH  = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/tape_ram_1w2r.sv
// Tape storage: one sync write port, two sync read ports (1-cycle, read-before-write).
// No backpressure: every port is accepted on every edge; read regs hold between reads.
module tape_ram_1w2r #(
  parameter int ADDR_W = 10,
  parameter int SYM_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [SYM_W-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [SYM_W-1:0]  rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [SYM_W-1:0]  rdata_b
);

  logic [SYM_W-1:0] mem [2**ADDR_W];

  // Array is never reset; the responder's blanking sweep initialises it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (re_a) rdata_a <= mem[raddr_a];
      if (re_b) rdata_b <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/tape_mem_responder.sv
// Tape memory responder: display read port (latency 1, never stalled) plus TM r/w port (ack after 1).
// TM requests are ignored while a blanking sweep runs; requester holds until tm_ack.
module tape_mem_responder
  import tape_pkg::*;
#(
  parameter int               ADDR_W    = DEF_ADDR_W,
  parameter int               SYM_W     = DEF_SYM_W,
  parameter logic [SYM_W-1:0] CLEAR_SYM = SYM_W'(SYM_BLANK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_access,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [SYM_W-1:0]  mem_in,
  input  logic              tm_access,
  input  logic              tm_rw,
  input  logic [ADDR_W-1:0] tm_addr,
  input  logic [SYM_W-1:0]  tm_wdata,
  output logic [SYM_W-1:0]  tm_rdata,
  output logic              tm_ack,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              ack_nxt, done_nxt;
  logic              ram_we, tm_re;
  logic [ADDR_W-1:0] ram_waddr;
  logic [SYM_W-1:0]  ram_wdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= CLEAR;
      cnt        <= '0;
      tm_ack     <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      tm_ack     <= ack_nxt;
      clear_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = 1'b0;
    done_nxt  = 1'b0;
    ram_we    = 1'b0;
    tm_re     = 1'b0;
    ram_waddr = tm_addr;
    ram_wdata = tm_wdata;
    case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt;
        ram_wdata = CLEAR_SYM;
        cnt_nxt   = cnt + ADDR_W'(1);
        if (&cnt) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      IDLE: begin
        if (tm_access) begin
          ack_nxt = 1'b1;
          ram_we  = !tm_rw;
          tm_re   = tm_rw;
        end
        // A clear request still lets this cycle's TM transaction complete.
        if (clear_req) begin
          cnt_nxt   = '0;
          state_nxt = CLEAR;
        end
      end
      default: state_nxt = CLEAR;
    endcase
    if (!rst) begin
      ram_we = 1'b0;
      tm_re  = 1'b0;
    end
  end

  assign busy = (state == CLEAR);

  tape_ram_1w2r #(
    .ADDR_W (ADDR_W),
    .SYM_W  (SYM_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .re_a    (mem_access && mem_rw),
    .raddr_a (mem_addr),
    .rdata_a (mem_in),
    .re_b    (tm_re),
    .raddr_b (tm_addr),
    .rdata_b (tm_rdata)
  );

endmodule
